uart_rx: RTL and testbench
==========================

# uart_rx

UART receive path for the low-power multi-clock communication system, the counterpart of the UART transmitter on the same serial line. It oversamples the incoming serial line at PRESCALE clocks per bit, detects and qualifies the start bit, recovers data bits LSB-first by 3-sample majority vote, checks optional parity and the stop bit, and presents the byte on a one-cycle valid pulse. It sits in the UART clock domain between the synchronized RX pin and the system-side data synchronizer.

## Interface

- DATA_WIDTH, 8, payload bits per frame
- CLK  in  1  UART oversampling clock
- RST  in  1  asynchronous active-low reset
- RX_IN  in  1  serial line, idle high, already synchronized to CLK
- PRESCALE  in  6  clocks per bit; legal values 8, 16, 32
- PAR_EN  in  1  1 = frame carries a parity bit after the data bits
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- P_DATA  out  DATA_WIDTH  last correctly received byte
- DATA_VALID  out  1  one-cycle pulse, P_DATA updated this cycle
- PAR_ERR  out  1  one-cycle pulse, parity mismatch on the frame just ended
- STP_ERR  out  1  one-cycle pulse, stop bit sampled low on the frame just ended

## Operation

- Frame: start (0), DATA_WIDTH data bits LSB-first, optional parity, stop (1). Every bit lasts exactly P = PRESCALE clocks.
- PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- Edge counter runs 0..P-1 inside each bit and wraps to 0 at each bit boundary. Bit counter indexes data bits 0..DATA_WIDTH-1.
- Sampler captures RX_IN at edge counts P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples, evaluated at edge count P-1.
- States:
  - IDLE: edge_cnt held 0. If RX_IN = 0, go to START; this cycle counts as edge 0.
  - START: at edge P-1, if voted bit = 1 (glitch), go to IDLE with no outputs. Otherwise go to DATA.
  - DATA: at edge P-1, shift the voted bit into the shift register at position bit_cnt. After bit DATA_WIDTH-1, go to PARITY if PAR_EN = 1, else to STOP.
  - PARITY: at edge P-1, compare the voted bit to the expected parity and record a parity error flag. Expected parity is XOR of the data bits for even, and its inverse for odd. Go to STOP.
  - STOP: at edge P-1, record stop error = (voted bit == 0), then go to IDLE.
- Frame end, registered in the cycle after the STOP bit's edge P-1:
  - PAR_ERR pulses iff the parity flag is set (only possible when PAR_EN = 1).
  - STP_ERR pulses iff the stop error is set.
  - If neither error is set: DATA_VALID pulses and P_DATA loads the shift register. Otherwise P_DATA holds its previous value.
- A frame with both errors pulses both PAR_ERR and STP_ERR. DATA_VALID stays 0.

## Timing

- Reset (RST = 0, asynchronous): state IDLE, counters 0, shift register 0, P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0. Reset mid-frame abandons the frame with no output pulse.
- Frame length is (2 + DATA_WIDTH + PAR_EN) * P clocks, counted from the first low cycle seen in IDLE.
- Output pulses appear exactly one cycle after the last clock of the stop bit and last exactly one cycle.
- Back-to-back frames: IDLE is entered on the cycle after the stop bit ends. If RX_IN is already low on that cycle, it is the next frame's edge 0, so there are no lost cycles.
- A false start is rejected at edge P-1 of the start bit. The FSM then re-arms in IDLE the following cycle.
- Low pulses shorter than P/2-1 clocks at the start position are always rejected.

## Test plan

- P = 8, PAR_EN = 1, PAR_TYP = 0, frame 0xA5 with parity 0 and stop 1 -> DATA_VALID pulse at cycle 88 after the start edge, P_DATA = 0xA5, no error pulses.
- P = 8, RX_IN low for 2 cycles, then high -> return to IDLE after 8 cycles; no DATA_VALID, PAR_ERR or STP_ERR pulse; a following good frame 0x5A is received correctly.
- P = 16, PAR_EN = 1, PAR_TYP = 1, byte 0x3C sent with parity bit 0 (1 expected) -> PAR_ERR single pulse, DATA_VALID = 0, P_DATA keeps its prior value.
- P = 16, PAR_EN = 0, byte 0xFF with stop bit 0 -> STP_ERR single pulse, DATA_VALID = 0.
- P = 32, PAR_EN = 0, frames 0x01, 0x80, 0x00 sent back-to-back with no idle gap -> three DATA_VALID pulses exactly 320 cycles apart with the correct bytes. Also, a single-cycle glitch at sample P/2 in one data bit is corrected by the majority vote.
- RST asserted during data bit 4 of a frame -> all outputs 0 immediately, no pulse; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - bundled serial/config/result signals of the UART receiver
//
// Purpose: groups the serial input, frame configuration and received-byte
// outputs of uart_rx into one interface.
// Signals:
//   RX_IN      serial line, idle high, synchronized to CLK
//   PRESCALE   clocks per bit (8, 16 or 32)
//   PAR_EN     frame carries a parity bit
//   PAR_TYP    0 = even, 1 = odd parity
//   P_DATA     last correctly received byte
//   DATA_VALID one-cycle pulse, P_DATA updated
//   PAR_ERR    one-cycle pulse, parity mismatch
//   STP_ERR    one-cycle pulse, stop bit sampled low
// Modports: master drives the line/config, slave is the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, parity and stop check
//
// Purpose: oversamples RX_IN at PRESCALE clocks per bit, qualifies the start
// bit, recovers DATA_WIDTH bits LSB-first by 3-sample majority, checks
// optional parity and the stop bit, and reports the frame with one-cycle
// pulses one cycle after the last clock of the stop bit.
// Ports:
//   CLK  UART oversampling clock
//   RST  asynchronous active-low reset
//   bus  uart_rx_if.slave: RX_IN/PRESCALE/PAR_EN/PAR_TYP in,
//        P_DATA/DATA_VALID/PAR_ERR/STP_ERR out
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [5:0]            prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [2:0]            samples;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_flag;

  logic [5:0] half;
  logic       edge_last;
  logic       bit_last;
  logic       start_det;
  logic       vote;

  assign half      = prescale_q >> 1;
  assign edge_last = (edge_cnt == prescale_q - 6'd1);
  assign bit_last  = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign start_det = (state_q == IDLE) && !bus.RX_IN;
  assign vote      = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!bus.RX_IN) state_d = START;
      START:  if (edge_last) state_d = vote ? IDLE : DATA;
      DATA:   if (edge_last && bit_last) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (edge_last) state_d = STOP;
      STOP:   if (edge_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q     <= 6'd8;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      samples        <= '0;
      shreg          <= '0;
      par_flag       <= 1'b0;
      bus.P_DATA     <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
    end else begin
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;

      // The cycle that sees the first low level is edge 0 of the start bit,
      // so the counter leaves IDLE already at 1.
      if (start_det) begin
        prescale_q <= bus.PRESCALE;
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
        edge_cnt   <= 6'd1;
        bit_cnt    <= '0;
        par_flag   <= 1'b0;
      end else if (state_q == IDLE) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_last ? 6'd0 : edge_cnt + 6'd1;
      end

      if (state_q != IDLE) begin
        if (edge_cnt == half - 6'd1) samples[0] <= bus.RX_IN;
        if (edge_cnt == half)        samples[1] <= bus.RX_IN;
        if (edge_cnt == half + 6'd1) samples[2] <= bus.RX_IN;
      end

      if (state_q == DATA && edge_last) begin
        shreg[bit_cnt] <= vote;
        bit_cnt        <= bit_cnt + BW'(1);
      end

      if (state_q == PARITY && edge_last)
        par_flag <= vote ^ (^shreg) ^ par_typ_q;

      if (state_q == STOP && edge_last) begin
        bus.PAR_ERR <= par_flag;
        bus.STP_ERR <= !vote;
        if (!par_flag && vote) begin
          bus.DATA_VALID <= 1'b1;
          bus.P_DATA     <= shreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: any output pulse is matched against the next expected frame result.
  always @(negedge clk) begin
    if (rst && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 3'b000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_valid", bus.DATA_VALID, e.dv);
        check("par_err", bus.PAR_ERR, e.pe);
        check("stp_err", bus.STP_ERR, e.se);
        check("p_data", bus.P_DATA, e.data);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic drive_level(input logic v, input int n);
    bus.RX_IN = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame; glitch_bit >= 0 inverts that data bit for one cycle at edge P/2.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit par_bit, input bit stop, input int glitch_bit,
                            input bit x_dv, input bit x_pe, input bit x_se,
                            input logic [7:0] x_data);
    logic bits[$];
    exp_t e;
    int   t0;
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par_bit);
    bits.push_back(stop);
    t0     = cyc;
    e.dv   = x_dv;
    e.pe   = x_pe;
    e.se   = x_se;
    e.data = x_data;
    e.at   = t0 + bits.size() * p;
    exp_q.push_back(e);
    for (int i = 0; i < bits.size(); i++) begin
      for (int k = 0; k < p; k++) begin
        bus.RX_IN = bits[i] ^ ((i == glitch_bit + 1) && (glitch_bit >= 0) && (k == p / 2));
        @(posedge clk);
        #1;
      end
    end
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_data", bus.P_DATA, 8'h00);
    check("rst_data_valid", bus.DATA_VALID, 1'b0);
    check("rst_par_err", bus.PAR_ERR, 1'b0);
    check("rst_stp_err", bus.STP_ERR, 1'b0);
    rst = 1'b1;
    drive_level(1'b1, 4);

    // P=8 even parity, 0xA5 (four ones -> parity 0): valid at cycle 88.
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hA5);
    drive_level(1'b1, 5);

    // False start: two low cycles, then a good 0x5A frame.
    bus.PRESCALE = 6'd8;
    drive_level(1'b0, 2);
    drive_level(1'b1, 12);
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h5A);
    drive_level(1'b1, 5);

    // P=16 odd parity, 0x3C needs parity 1; sending 0 -> PAR_ERR, P_DATA keeps 0x5A.
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h5A);
    drive_level(1'b1, 5);

    // P=16 no parity, 0xFF with stop 0 -> STP_ERR.
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h5A);
    drive_level(1'b1, 5);

    // Reset in the middle of data bit 4 of a 0xC3 frame (bits 0..3 = 1,1,0,0).
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b0;
    drive_level(1'b0, 16);
    drive_level(1'b1, 32);
    drive_level(1'b0, 32);
    drive_level(1'b0, 8);
    #2 rst = 1'b0;
    #1;
    check("midrst_p_data", bus.P_DATA, 8'h00);
    check("midrst_data_valid", bus.DATA_VALID, 1'b0);
    check("midrst_par_err", bus.PAR_ERR, 1'b0);
    check("midrst_stp_err", bus.STP_ERR, 1'b0);
    bus.RX_IN = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_level(1'b1, 5);
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hC3);
    drive_level(1'b1, 5);

    // P=32 back-to-back, glitch in data bit 3 of 0x80; pulses 320 cycles apart.
    send_frame(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h01);
    send_frame(8'h80, 32, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 8'h80);
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h00);
    drive_level(1'b1, 40);

    check("pending_expectations", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
